// File: rtl/deco_issue_seq.sv
// Decode-stage issue sequencer: captures one instruction per handshake,
// sign-extends its immediate and issues scalar (1 beat) or vector beats.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous pipeline flush (drops any pending beats)
//   in_valid/ready  fetch handshake; in_instr is the instruction word
//   out_valid/ready execute handshake for each issued beat
//   out_instr       captured instruction, stable for all of its beats
//   out_imm         sext(imm) + beat*BEAT_STRIDE (wraps mod 2^DATA_W)
//   out_beat        beat index within the instruction
//   out_last        final beat of the instruction
//   stall_cnt       saturating count of out_valid && !out_ready cycles
module deco_issue_seq #(
    parameter int INSTR_W     = 32,
    parameter int IMM_W       = 19,
    parameter int DATA_W      = 32,
    parameter int NUM_BEATS   = 4,
    parameter int BEAT_STRIDE = 4,
    parameter int VEC_BIT     = 26,
    localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_imm,
    output logic [BEAT_W-1:0]  out_beat,
    output logic               out_last,
    output logic [15:0]        stall_cnt
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] SCALAR = 2'd1;
    localparam logic [1:0] VECTOR = 2'd2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [DATA_W-1:0] STRIDE    = DATA_W'(BEAT_STRIDE);

    logic [1:0]         state;
    logic [1:0]         state_d;
    logic [INSTR_W-1:0] instr_d;
    logic [DATA_W-1:0]  imm_d;
    logic [BEAT_W-1:0]  beat_d;
    logic               last_d;
    logic [15:0]        stall_d;

    logic               in_fire;
    logic               out_fire;
    logic               stalled;
    logic [DATA_W-1:0]  sext_imm;
    logic [BEAT_W-1:0]  beat_nxt;

    assign out_valid = (state != EMPTY);
    assign out_fire  = out_valid && out_ready;
    assign stalled   = out_valid && !out_ready;

    // Ready depends on out_ready so a completing final beat can be
    // replaced in the same cycle (no bubble between scalars).
    assign in_ready = !rst && !flush &&
                      ((state == EMPTY) || (out_fire && out_last));
    assign in_fire  = in_valid && in_ready;

    assign sext_imm = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}},
                       in_instr[IMM_W-1:0]};
    assign beat_nxt = out_beat + 1'b1;

    always_comb begin
        state_d = state;
        instr_d = out_instr;
        imm_d   = out_imm;
        beat_d  = out_beat;
        last_d  = out_last;
        if (flush) begin
            // Pending beats are dropped; payload fields are left as-is.
            state_d = EMPTY;
            last_d  = 1'b0;
        end else if (in_fire) begin
            instr_d = in_instr;
            imm_d   = sext_imm;
            beat_d  = '0;
            if (in_instr[VEC_BIT]) begin
                state_d = VECTOR;
                last_d  = 1'b0;
            end else begin
                state_d = SCALAR;
                last_d  = 1'b1;
            end
        end else if (out_fire) begin
            if (out_last) begin
                state_d = EMPTY;
                last_d  = 1'b0;
            end else begin
                beat_d = beat_nxt;
                imm_d  = out_imm + STRIDE;
                last_d = (beat_nxt == LAST_BEAT);
            end
        end
    end

    // Stall counting is independent of flush; only reset clears it.
    always_comb begin
        stall_d = stall_cnt;
        if (stalled && (stall_cnt != 16'hFFFF)) begin
            stall_d = stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_instr <= '0;
            out_imm   <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_d;
            out_instr <= instr_d;
            out_imm   <= imm_d;
            out_beat  <= beat_d;
            out_last  <= last_d;
            stall_cnt <= stall_d;
        end
    end

endmodule

// File: tb/tb_deco_issue_seq.sv
// Directed testbench for deco_issue_seq: scalar sign extension, back-to-back
// scalars, vector beats with wrap, backpressure, flush and reset.
module tb_deco_issue_seq;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [1:0]  out_beat;
    logic        out_last;
    logic [15:0] stall_cnt;

    int n_pass;
    int n_total;

    deco_issue_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_imm   (out_imm),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] imm,
                            input int beat, input logic last,
                            input logic rdy);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_beat"}, 32'(out_beat), 32'(beat));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
        chk({tag, "_inrdy"}, 32'(in_ready), 32'(rdy));
    endtask

    logic [31:0] sc_in  [4];
    logic [31:0] sc_exp [4];
    logic [31:0] v1_exp [4];
    logic [31:0] v2_exp [4];

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'h0;

        sc_in[0] = 32'h0004_0000; sc_exp[0] = 32'hFFFC_0000;
        sc_in[1] = 32'h0003_FFFF; sc_exp[1] = 32'h0003_FFFF;
        sc_in[2] = 32'h0000_0001; sc_exp[2] = 32'h0000_0001;
        sc_in[3] = 32'h0007_FFFF; sc_exp[3] = 32'hFFFF_FFFF;
        v1_exp[0] = 32'h0003_FFFF; v1_exp[1] = 32'h0004_0003;
        v1_exp[2] = 32'h0004_0007; v1_exp[3] = 32'h0004_000B;
        v2_exp[0] = 32'hFFFF_FFFC; v2_exp[1] = 32'h0000_0000;
        v2_exp[2] = 32'h0000_0004; v2_exp[3] = 32'h0000_0008;

        // Reset
        settle();
        chk("rst_inrdy", 32'(in_ready), 32'd0);
        nxt(); settle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_beat", 32'(out_beat), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_inrdy2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        settle();
        chk("empty_inrdy", 32'(in_ready), 32'd1);

        // Back-to-back scalars, including sign extension cases
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = sc_in[0];
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i < 4) in_instr = sc_in[i];
            else in_valid = 1'b0;
            settle();
            chk_beat($sformatf("sc%0d", i-1), sc_exp[i-1], 0, 1'b1, 1'b1);
            chk($sformatf("sc%0d_instr", i-1), out_instr, sc_in[i-1]);
        end
        nxt(); settle();
        chk("sc_done_valid", 32'(out_valid), 32'd0);

        // Vector, imm 0x3FFFF
        in_valid = 1'b1;
        in_instr = 32'h0403_FFFF;
        for (int k = 0; k < 4; k++) begin
            nxt();
            in_valid = 1'b0;
            settle();
            chk_beat($sformatf("v1b%0d", k), v1_exp[k], k, k == 3, k == 3);
            chk($sformatf("v1b%0d_instr", k), out_instr, 32'h0403_FFFF);
        end
        nxt(); settle();
        chk("v1_done_valid", 32'(out_valid), 32'd0);

        // Vector with wrap, imm -4
        in_valid = 1'b1;
        in_instr = 32'h0407_FFFC;
        for (int k = 0; k < 4; k++) begin
            nxt();
            in_valid = 1'b0;
            settle();
            chk_beat($sformatf("v2b%0d", k), v2_exp[k], k, k == 3, k == 3);
        end
        nxt(); settle();
        chk("v2_done_valid", 32'(out_valid), 32'd0);
        chk("v2_stall", 32'(stall_cnt), 32'd0);

        // Backpressure on beat 1
        in_valid = 1'b1;
        in_instr = 32'h0400_0010;
        nxt();
        in_valid = 1'b0;
        settle();
        chk_beat("bp_b0", 32'h10, 0, 1'b0, 1'b0);
        nxt();
        out_ready = 1'b0;
        settle();
        chk_beat("bp_b1", 32'h14, 1, 1'b0, 1'b0);
        for (int s = 1; s <= 5; s++) begin
            nxt();
            if (s == 5) out_ready = 1'b1;
            settle();
            chk($sformatf("bp_s%0d_stall", s), 32'(stall_cnt), 32'(s));
            chk($sformatf("bp_s%0d_imm", s), out_imm, 32'h14);
            chk($sformatf("bp_s%0d_beat", s), 32'(out_beat), 32'd1);
            chk($sformatf("bp_s%0d_instr", s), out_instr, 32'h0400_0010);
            chk($sformatf("bp_s%0d_valid", s), 32'(out_valid), 32'd1);
        end
        nxt(); settle();
        chk_beat("bp_b2", 32'h18, 2, 1'b0, 1'b0);
        nxt(); settle();
        chk_beat("bp_b3", 32'h1C, 3, 1'b1, 1'b1);
        nxt(); settle();
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_done_stall", 32'(stall_cnt), 32'd5);

        // Flush on beat 2 with a competing in_valid
        in_valid = 1'b1;
        in_instr = 32'h0400_0100;
        nxt();
        in_valid = 1'b0;
        settle();
        chk_beat("fl_b0", 32'h100, 0, 1'b0, 1'b0);
        nxt(); settle();
        chk_beat("fl_b1", 32'h104, 1, 1'b0, 1'b0);
        nxt();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0400_0005;
        settle();
        chk("fl_cyc_inrdy", 32'(in_ready), 32'd0);
        chk("fl_cyc_beat", 32'(out_beat), 32'd2);
        nxt();
        flush = 1'b0;
        settle();
        chk("fl_after_valid", 32'(out_valid), 32'd0);
        chk("fl_after_inrdy", 32'(in_ready), 32'd1);
        nxt();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        settle();
        chk_beat("fl_new_b0", 32'h5, 0, 1'b0, 1'b0);
        chk("fl_new_instr", out_instr, 32'h0400_0005);
        chk("fl_new_stall", 32'(stall_cnt), 32'd5);

        // Reset mid-vector after two stalled cycles
        nxt(); settle();
        chk("rv_stall6", 32'(stall_cnt), 32'd6);
        nxt();
        rst = 1'b1;
        settle();
        chk("rv_stall7", 32'(stall_cnt), 32'd7);
        chk("rv_inrdy", 32'(in_ready), 32'd0);
        nxt();
        rst       = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("rv_valid", 32'(out_valid), 32'd0);
        chk("rv_stall", 32'(stall_cnt), 32'd0);
        chk("rv_beat", 32'(out_beat), 32'd0);
        chk("rv_imm", out_imm, 32'd0);
        chk("rv_last", 32'(out_last), 32'd0);
        nxt(); settle();
        chk("rv_valid2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/deco_issue_seq.md
Name: deco_issue_seq

Overview:
Decode-stage issue sequencer between fetch and execute. It captures one instruction per handshake and sign-extends its 19-bit immediate to 32 bits in the capture cycle. Scalar instructions issue to execute as one beat. Vector instructions issue as NUM_BEATS consecutive beats, each carrying a lane index and a stride-adjusted immediate (vector load/store addressing).

Parameters:
INSTR_W, 32, instruction width
IMM_W, 19, immediate field width, instr[IMM_W-1:0], two's complement
DATA_W, 32, extended immediate width
NUM_BEATS, 4, beats per vector instruction (>=2)
BEAT_STRIDE, 4, immediate increment per beat
VEC_BIT, 26, instr bit that marks a vector instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous pipeline flush
in_valid  in  1  fetch has an instruction
in_ready  out  1  sequencer accepts this cycle
in_instr  in  INSTR_W  instruction word
out_valid  out  1  beat presented to execute
out_ready  in  1  execute accepts beat
out_instr  out  INSTR_W  captured instruction, stable for all beats
out_imm  out  DATA_W  sext(imm) + beat*BEAT_STRIDE, mod 2^DATA_W
out_beat  out  clog2(NUM_BEATS)  beat index
out_last  out  1  final beat of the instruction
stall_cnt  out  16  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Reset values:
  - state=EMPTY, out_valid=0, out_instr=0, out_imm=0, out_beat=0, out_last=0, stall_cnt=0.
  - in_ready=0 during the reset cycle.
- States: EMPTY, SCALAR, VECTOR.
- Handshakes:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - out_valid = (state != EMPTY).
- in_ready = !rst && !flush && (state==EMPTY || (out_fire && out_last)). This is combinational from out_ready, so back-to-back scalar instructions issue at 1 per cycle.
- Capture on in_fire (registered, 1-cycle latency to out_valid):
  - out_instr <= in_instr.
  - base_imm <= {(DATA_W-IMM_W){in_instr[IMM_W-1]}, in_instr[IMM_W-1:0]}.
  - out_imm <= base_imm, out_beat <= 0.
  - If in_instr[VEC_BIT]: state <= VECTOR, out_last <= 0.
  - Otherwise: state <= SCALAR, out_last <= 1.
- SCALAR: on out_fire, go to EMPTY, or recapture if in_fire in the same cycle.
- VECTOR, on out_fire with !out_last:
  - out_beat <= out_beat+1.
  - out_imm <= out_imm + BEAT_STRIDE, wrapping at 2^DATA_W with no saturation.
  - out_last <= (out_beat+1 == NUM_BEATS-1).
- VECTOR, on out_fire with out_last: same as SCALAR completion.
- Stall: while out_valid && !out_ready, every output is held unchanged.
- stall_cnt:
  - Increments on each cycle with out_valid && !out_ready.
  - Saturates at 0xFFFF.
  - Cleared only by rst; flush does not clear it.
- flush (priority below rst, above everything else):
  - Next state is EMPTY and out_valid=0 on the next cycle.
  - Any remaining vector beats are discarded.
  - in_ready=0 in the flush cycle, so nothing is captured.
  - out_instr, out_imm and out_beat keep their values (don't-care).
- rst mid-vector: all state returns to reset values on the next edge, and no further beats issue.
- out_fire and flush in the same cycle: the beat counts as accepted by execute, and the sequencer still goes EMPTY.
- Invariants:
  - out_beat < NUM_BEATS.
  - out_last=1 iff (SCALAR) or (VECTOR && out_beat==NUM_BEATS-1).
  - Exactly one out_last beat per captured instruction unless flushed or reset.

Test Plan:
- Scalar sign extension: instr imm field 0x40000 (bit18=1), out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFC0000, out_last=1, out_beat=0. Imm field 0x3FFFF -> out_imm=0x0003FFFF.
- Back-to-back scalars: in_valid=1 for 4 cycles, out_ready=1 -> 4 beats on 4 consecutive cycles, in_ready held 1 after the first capture, no bubbles.
- Vector, imm 0x3FFFF: 4 beats with out_imm = 0x0003FFFF, 0x00040003, 0x00040007, 0x0004000B; out_beat = 0..3; out_last only on beat 3; in_ready=0 during beats 0-2.
- Vector with wrap, imm 0x7FFFC (-4): out_imm = 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
- Backpressure: out_ready=0 for 5 cycles on vector beat 1 -> all outputs stable and stall_cnt=5. Then out_ready=1 -> beats 2 and 3 follow on consecutive cycles.
- Flush at beat 2 of a vector, in_valid=1 in the same cycle -> no capture, out_valid=0 on the next cycle. Next instruction captured the following cycle with out_beat=0. A rst pulse mid-vector -> stall_cnt=0, out_valid=0.
